// File: rtl/wide_adder_sequencer.sv
// rtl/wide_adder_sequencer.sv - wide add/subtract built from one 32-bit slice reused over WORDS limbs
module wide_adder_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);

  localparam int W  = 32 * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;

  logic [31:0]     limb_a;
  logic [31:0]     limb_b;
  logic [32:0]     slice;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign limb_a = a_q[32*k +: 32];
  assign limb_b = b_q[32*k +: 32];
  assign slice  = {1'b0, limb_a} + {1'b0, limb_b} + {32'd0, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            a_q   <= in_a;
            b_q   <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          out_sum[32*k +: 32] <= slice[31:0];
          carry               <= slice[32];
          if (k == K_LAST) begin
            out_cout <= slice[32];
            out_ovf  <= (a_q[W-1] == b_q[W-1]) && (slice[31] != a_q[W-1]);
            k        <= '0;
            state    <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// tb/tb_wide_adder_sequencer.sv - directed-vector bench for wide_adder_sequencer (WORDS=4)
module tb_wide_adder_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_adder_sequencer #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one request from IDLE, then wait (bounded) for out_valid; lat counts negedges after accept.
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic sub, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  int lat;
  int stray;
  logic [127:0] held;

  initial begin
    // Reset held with a request pending: nothing accepted, outputs cleared.
    in_a = 128'd10; in_b = 128'd20; in_sub = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    expect_eq("rst_out_valid", 128'(out_valid), 128'd0);
    expect_eq("rst_out_sum", out_sum, 128'd0);
    expect_eq("rst_cout", 128'(out_cout), 128'd0);
    expect_eq("rst_ovf", 128'(out_ovf), 128'd0);
    expect_eq("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    expect_eq("first_edge_accept", 128'(in_ready), 128'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    expect_eq("first_op_valid", 128'(out_valid), 128'd1);
    expect_eq("first_op_sum", out_sum, 128'd30);
    release_result();

    // Carry ripple through three limbs.
    run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, lat);
    expect_eq("carry_valid", 128'(out_valid), 128'd1);
    expect_eq("carry_latency", 128'(lat), 128'd5);
    expect_eq("carry_sum", out_sum, 128'h00000001_00000000_00000000_00000000);
    expect_eq("carry_cout", 128'(out_cout), 128'd0);
    expect_eq("carry_ovf", 128'(out_ovf), 128'd0);
    release_result();

    // Subtract with and without borrow.
    run_op(128'd0, 128'd1, 1'b1, lat);
    expect_eq("sub_borrow_sum", out_sum, {128{1'b1}});
    expect_eq("sub_borrow_cout", 128'(out_cout), 128'd0);
    expect_eq("sub_borrow_ovf", 128'(out_ovf), 128'd0);
    release_result();
    run_op(128'd5, 128'd3, 1'b1, lat);
    expect_eq("sub_plain_sum", out_sum, 128'd2);
    expect_eq("sub_plain_cout", 128'(out_cout), 128'd1);
    release_result();

    // Signed overflow on add and subtract.
    run_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, lat);
    expect_eq("ovf_add_sum", out_sum, {1'b1, 127'd0});
    expect_eq("ovf_add_ovf", 128'(out_ovf), 128'd1);
    expect_eq("ovf_add_cout", 128'(out_cout), 128'd0);
    release_result();
    run_op({1'b1, 127'd0}, 128'd1, 1'b1, lat);
    expect_eq("ovf_sub_sum", out_sum, {1'b0, {127{1'b1}}});
    expect_eq("ovf_sub_ovf", 128'(out_ovf), 128'd1);
    expect_eq("ovf_sub_cout", 128'(out_cout), 128'd1);
    release_result();

    // Backpressure: DONE held, then next request accepted one cycle after the handshake.
    run_op(128'd100, 128'd200, 1'b0, lat);
    held = out_sum;
    expect_eq("bp_sum", held, 128'd300);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_eq("bp_valid_hold", 128'(out_valid), 128'd1);
      expect_eq("bp_in_ready_low", 128'(in_ready), 128'd0);
      expect_eq("bp_sum_hold", out_sum, held);
    end
    in_a = 128'd7; in_b = 128'd8; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    expect_eq("bp_handshake_idle", 128'(in_ready), 128'd1);
    expect_eq("bp_handshake_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    @(negedge clk);
    expect_eq("bp_next_accepted", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    expect_eq("bp_next_latency", 128'(lat), 128'd5);
    expect_eq("bp_next_sum", out_sum, 128'd15);
    release_result();

    // Reset pulse while k=2: result discarded, no stale out_valid.
    @(negedge clk);
    in_a = 128'd1; in_b = 128'd2; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_eq("midrun_rst_sum", out_sum, 128'd0);
    expect_eq("midrun_rst_valid", 128'(out_valid), 128'd0);
    expect_eq("midrun_rst_cout", 128'(out_cout), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    expect_eq("midrun_no_stale_valid", 128'(stray), 128'd0);
    run_op(128'h00000001_00000002_00000003_00000004,
           128'h10000000_20000000_30000000_40000000, 1'b0, lat);
    expect_eq("post_rst_valid", 128'(out_valid), 128'd1);
    expect_eq("post_rst_sum", out_sum, 128'h10000001_20000002_30000003_40000004);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wide_adder_sequencer.md
# wide_adder_sequencer

Multi-cycle sequencer that computes wide two's-complement add/subtract results by time-multiplexing a single 32-bit ripple-carry adder slice over `WORDS` limbs, least-significant limb first. The carry is held in a register between limbs. The block sits between a requester and a consumer, with a valid/ready handshake on each side. It trades latency for area in datapaths wider than 32 bits.

## Interface
- `WORDS`, default 4: number of 32-bit limbs; operand width is `32*WORDS`; legal range 2..16.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_a`  in  32*WORDS  operand A.
- `in_b`  in  32*WORDS  operand B.
- `in_sub`  in  1  0 = A+B, 1 = A−B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  32*WORDS  result.
- `out_cout`  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- `out_ovf`  out  1  signed overflow.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: limb index `k` counts 0..WORDS−1.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid & in_ready`:
  - latch `in_a` and `in_b`; latch B as `~in_b` when `in_sub`=1;
  - carry register ← `in_sub`;
  - `k` ← 0.
- RUN, each cycle:
  - adder slice inputs are limb `k` of A, limb `k` of B', and the carry register;
  - write the slice sum into limb `k` of `out_sum`;
  - carry register ← slice cout;
  - `k` ← `k`+1.
- RUN→DONE after limb WORDS−1 is written. On that same cycle:
  - `out_cout` ← slice cout;
  - `out_ovf` ← (A[msb] == B'[msb]) & (sum[msb] != A[msb]).
- DONE→IDLE on `out_ready`. `out_sum`, `out_cout` and `out_ovf` hold their values until the next write; only reset clears them.
- Non-pipelined: `in_ready`=0 in RUN and DONE. A request presented during the DONE→IDLE handshake cycle is not accepted; it is accepted on the next cycle at the earliest.
- `in_ready` = (state==IDLE) and is combinational from the state. `out_valid` = (state==DONE).
- Operand inputs are sampled only on the accept cycle. Changes at any other time have no effect.
- `out_sum` limbs update progressively during RUN. Consumers must qualify `out_sum` with `out_valid`.
- All arithmetic is modulo 2^(32*WORDS). The MSB is bit 32*WORDS−1.

## Timing
- Reset (`rst_n` low, async):
  - state = IDLE, `k` = 0, carry = 0;
  - `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0, `out_valid` = 0;
  - `in_ready` reads 1, but nothing is accepted while `rst_n` is low.
- Latency: for an accept at edge T, `out_valid` rises after edge T+WORDS. It is visible in cycle T+WORDS+1, i.e. 5 cycles after the accept for WORDS=4.
- Throughput: one result every WORDS+2 cycles when `out_ready` is tied high.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately and the result is discarded. There is no `out_valid` pulse after reset release.
- `out_ready` held low: the block stays in DONE indefinitely with all outputs stable.
- `out_ready` high while not in DONE: ignored.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_valid`=1 → `out_valid`=0 and `out_sum`=0. After release, the first accept happens on the first edge with `rst_n`=1.
- **Carry propagation (WORDS=4):** A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, add → `out_sum`=0x00000001_00000000_00000000_00000000, `cout`=0, `ovf`=0. `out_valid` is first seen 5 cycles after the accept.
- **Subtract borrow:** A=0, B=1, `in_sub`=1 → `out_sum`=all-ones, `cout`=0, `ovf`=0. Then A=5, B=3 → `out_sum`=2, `cout`=1.
- **Signed overflow:**
  - A=0x7FFF…FF, B=1, add → `out_sum`=0x8000…00, `ovf`=1, `cout`=0.
  - A=0x8000…00, B=1, sub → `out_sum`=0x7FFF…FF, `ovf`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0 throughout. Then assert `out_ready` while `in_valid`=1 → the next request is accepted exactly one cycle after the output handshake.
- **Reset mid-RUN:** pulse `rst_n` low at `k`=2 → all outputs return to reset values, and no stale `out_valid` appears afterwards. A fresh request then completes with the correct sum.
